// File: rtl/pivot_pkg.sv
// Shared types and helpers for the off-diagonal pivot selector.
// Candidate payload: signed value plus its (row, column) position.
package pivot_pkg;

  localparam int unsigned PIVOT_DATA_W = 16;
  localparam int unsigned PIVOT_IDX_W  = 4;

  typedef struct packed {
    logic signed [PIVOT_DATA_W-1:0] val;
    logic        [PIVOT_IDX_W-1:0]  i;
    logic        [PIVOT_IDX_W-1:0]  j;
  } cand_t;

  // Strict signed greater-than: equal values never displace the incumbent.
  function automatic logic cand_better(input cand_t a, input cand_t b);
    return $signed(a.val) > $signed(b.val);
  endfunction

endpackage

// File: rtl/pivot_cmp.sv
// Two-candidate compare-select; the left (earlier) operand is kept on ties.
module pivot_cmp
  import pivot_pkg::*;
(
  input  cand_t i_a,
  input  cand_t i_b,
  output cand_t o_best_c
);

  assign o_best_c = cand_better(i_b, i_a) ? i_b : i_a;

endmodule

// File: rtl/pivot_select.sv
// Selects the largest signed off-diagonal matrix entry and its position,
// registered one cycle after an accepted matrix.
module pivot_select
  import pivot_pkg::*;
#(
  parameter int unsigned N_STOCKS = 3,
  parameter int unsigned DATA_W   = PIVOT_DATA_W,
  parameter int unsigned IDX_W    = PIVOT_IDX_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] matrix [N_STOCKS][N_STOCKS],
  output logic        [IDX_W-1:0]  pivot_i,
  output logic        [IDX_W-1:0]  pivot_j,
  output logic signed [DATA_W-1:0] pivot_val,
  output logic                     out_valid
);

  localparam int unsigned N_CAND = N_STOCKS * (N_STOCKS - 1);
  localparam int unsigned N_LEAF = 1 << $clog2(N_CAND);
  localparam int unsigned N_NODE = 2 * N_LEAF - 1;

  // Heap layout: node k has children 2k+1 (earlier) and 2k+2 (later);
  // leaves occupy [N_LEAF-1 .. N_NODE-1] in row-major candidate order.
  cand_t w_node [N_NODE];

  genvar g;
  generate
    for (g = 0; g < N_LEAF; g++) begin : g_leaf
      if (g < N_CAND) begin : g_real
        localparam int unsigned ROW = g / (N_STOCKS - 1);
        localparam int unsigned RC  = g % (N_STOCKS - 1);
        localparam int unsigned COL = (RC < ROW) ? RC : RC + 1;
        assign w_node[N_LEAF-1+g] = '{
          val: PIVOT_DATA_W'(matrix[ROW][COL]),
          i:   PIVOT_IDX_W'(ROW),
          j:   PIVOT_IDX_W'(COL)
        };
      end else begin : g_pad
        // Padding sits right of every real candidate, so it loses even at the minimum value.
        assign w_node[N_LEAF-1+g] = '{
          val: {1'b1, {(PIVOT_DATA_W-1){1'b0}}},
          i:   '0,
          j:   '0
        };
      end
    end

    for (g = 0; g < N_LEAF - 1; g++) begin : g_tree
      pivot_cmp u_cmp (
        .i_a      (w_node[2*g+1]),
        .i_b      (w_node[2*g+2]),
        .o_best_c (w_node[g])
      );
    end
  endgenerate

  logic        [IDX_W-1:0]  r_pivot_i;
  logic        [IDX_W-1:0]  r_pivot_j;
  logic signed [DATA_W-1:0] r_pivot_val;
  logic                     r_out_valid;

  // Output stage: capture on accept, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pivot_i   <= '0;
      r_pivot_j   <= '0;
      r_pivot_val <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_pivot_i   <= IDX_W'(w_node[0].i);
        r_pivot_j   <= IDX_W'(w_node[0].j);
        r_pivot_val <= DATA_W'(w_node[0].val);
      end
    end
  end

  assign pivot_i   = r_pivot_i;
  assign pivot_j   = r_pivot_j;
  assign pivot_val = r_pivot_val;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_pivot_select.sv
// Scoreboard bench for pivot_select (N_STOCKS=3): directed matrices with
// hand-computed pivots, checked by an independent monitor process.
module tb_pivot_select;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic signed [15:0] matrix [3][3];
  logic        [3:0]  pivot_i;
  logic        [3:0]  pivot_j;
  logic signed [15:0] pivot_val;
  logic               out_valid;

  typedef struct {
    int i;
    int j;
    int v;
  } exp_t;

  exp_t exp_q [$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   m [9];

  pivot_select #(.N_STOCKS(3), .DATA_W(16), .IDX_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .matrix    (matrix),
    .pivot_i   (pivot_i),
    .pivot_j   (pivot_j),
    .pivot_val (pivot_val),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic load();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        matrix[r][c] = 16'(m[r*3+c]);
  endtask

  // Present m with in_valid=1 and record the expected pivot.
  task automatic apply(input int ei, input int ej, input int ev);
    exp_t e;
    @(negedge clk);
    load();
    in_valid = 1'b1;
    e.i = ei; e.j = ej; e.v = ev;
    exp_q.push_back(e);
  endtask

  task automatic chk_outs(input string name, input int ei, input int ej,
                          input int ev, input int eov);
    chk({name, ".i"},     int'(pivot_i), ei);
    chk({name, ".j"},     int'(pivot_j), ej);
    chk({name, ".val"},   int'(pivot_val), ev);
    chk({name, ".valid"}, int'(out_valid), eov);
  endtask

  // Monitor: every edge out of reset, out_valid must match a queued result exactly.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            chk("spurious_out_valid", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("mon.i",   int'(pivot_i), e.i);
            chk("mon.j",   int'(pivot_j), e.j);
            chk("mon.val", int'(pivot_val), e.v);
          end
        end else if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("mon.latency_out_valid", 0, 1);
        end
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    m = '{16'h1234, 16'h7fff, 16'h0bad, 16'h5555, 16'h0001, 16'h7ffe, 16'h3333, 16'h4444, 16'h6666};
    load();

    // Reset with garbage and in_valid high: everything stays zero.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk_outs("reset", 0, 0, 0, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    chk_outs("post_reset_idle", 0, 0, 0, 0);

    // All positive; diagonal 1024 ignored.
    m = '{32, 128, 32, 272, 1024, 4, 1072, 1088, 1024};
    apply(2, 1, 1088);
    // Signed: large-magnitude negatives must lose.
    m = '{16'h0400, 16'h1000, 16'h8400, 16'h2200, 16'h8000, 16'h0080, 16'h8600, 16'h8800, 16'h8000};
    apply(1, 0, 16'h2200);
    // Tie on every off-diagonal; maximal diagonal ignored.
    m = '{16'h7fff, 5, 5, 5, 16'h7fff, 5, 5, 5, 16'h7fff};
    apply(0, 1, 5);
    // All negative off-diagonal.
    m = '{0, -1, -1, -1, 0, -1, -2, -1, 0};
    apply(0, 1, -1);
    // All off-diagonal at the most negative value.
    m = '{100, -32768, -32768, -32768, 100, -32768, -32768, -32768, 100};
    apply(0, 1, -32768);
    // Single winner at (1,2).
    m = '{100, 0, 0, 0, 100, 7, 0, 0, 100};
    apply(1, 2, 7);
    // Winner at (0,2), later equal values lose.
    m = '{0, -5, 9, 9, 0, 9, 9, 9, 0};
    apply(0, 2, 9);

    // New matrix without in_valid: outputs hold, out_valid drops.
    @(negedge clk);
    m = '{0, 300, 300, 300, 0, 300, 300, 300, 0};
    load();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_outs("hold", 0, 2, 9, 0);
    @(negedge clk);
    m = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    load();
    @(posedge clk);
    #1;
    chk_outs("hold2", 0, 2, 9, 0);

    // Mid-stream reset: in-flight result discarded, outputs clear immediately.
    m = '{0, 1, 2, 3, 0, 4, 5, 6, 0};
    apply(2, 1, 6);
    @(negedge clk);
    m = '{0, 50, 0, 0, 0, 0, 0, 0, 0};
    load();
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs("async_reset", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_outs("reset_hold", 0, 0, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // Recovery after reset.
    m = '{0, 3, 3, 8, 0, 8, 1, 2, 0};
    apply(1, 0, 8);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/pivot_select.md
# pivot_select

Off-diagonal pivot selector for the Jacobi eigen-solver datapath. Each accepted cycle it scans an N_STOCKS×N_STOCKS matrix of signed 16-bit entries. It returns the row/column of the largest signed off-diagonal element and that element's value, registered one cycle later. It sits between the covariance-matrix store and the rotation stage.

## Interface
Parameters:
- N_STOCKS, default 3: matrix dimension; legal range 2..16.
- DATA_W, default 16: entry width, two's-complement signed.
- IDX_W, default 4: index width; must satisfy 2^IDX_W ≥ N_STOCKS.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  matrix is valid this cycle.
- matrix  in  signed [DATA_W-1:0] [N_STOCKS-1:0][N_STOCKS-1:0]  unpacked, indexed matrix[row][col].
- pivot_i  out  IDX_W  row of the selected element.
- pivot_j  out  IDX_W  column of the selected element.
- pivot_val  out  signed DATA_W  value of the selected element.
- out_valid  out  1  outputs correspond to a matrix accepted last cycle.

## Operation
- Candidates: every (i,j) with i≠j. Diagonal entries are never selected, regardless of their value.
- Comparison is signed. Negative entries lose to any non-negative entry; no absolute value is taken.
- Result: the candidate with maximum signed value.
- Tie-break: the lowest row-major position wins (smallest i, then smallest j). The comparison is strict greater-than, so an earlier candidate is kept on equality.
- No symmetry is assumed; upper and lower triangles are both scanned.
- The selection is combinational over the full matrix. The result is captured into the output registers when in_valid=1.
- When in_valid=0, pivot_i, pivot_j and pivot_val hold their previous values.

## Timing
- Reset (rst_n=0, asynchronous): pivot_i=0, pivot_j=0, pivot_val=0, out_valid=0. All four are held until the first clk edge after rst_n deasserts.
- Latency: exactly 1 cycle. A matrix sampled with in_valid=1 at edge k produces its result and out_valid=1 after edge k.
- Throughput: one matrix per cycle. There is no backpressure.
- out_valid is a registered copy of in_valid.
- Reset asserted mid-stream: the in-flight result is discarded and the outputs return to their reset values immediately.
- Matrix values that change without in_valid have no effect on the outputs.

## Structure
- Package pivot_pkg holds:
  - DATA_W and IDX_W defaults;
  - a typedef cand_t {logic signed [DATA_W-1:0] val; logic [IDX_W-1:0] i, j;};
  - a function cand_better(a,b) returning a.val > b.val (signed, strict).
- Natural sub-module: pivot_cmp, a two-candidate compare-select that outputs the better cand_t and keeps the left (earlier) operand on ties.
- Top level: a balanced reduction tree of pivot_cmp instances over the N_STOCKS*(N_STOCKS-1) candidates in row-major order, followed by the output register stage.
- The tree ordering must preserve left-wins so that the tie-break holds.

## Test plan
- **Reset:** hold rst_n=0 with garbage on matrix and in_valid=1 → all outputs stay 0 and out_valid=0.
- **All positive, N=3:** row0 = {32,128,32}, row1 = {272,1024,4}, row2 = {1072,1088,1024}.
  - Required result 1 cycle later: pivot_i=2, pivot_j=1, pivot_val=1088, out_valid=1.
  - The diagonal value 1024 must be ignored.
- **Signed entries, N=3:**
  - row0 = {0x0400, 0x1000, 0x8400};
  - row1 = {0x2200, 0x8000, 0x0080};
  - row2 = {0x8600, 0x8800, 0x8000};
  - required result: (1,0) with pivot_val=0x2200. The large-magnitude negatives must not win.
- **Tie:** all off-diagonal entries = 5 and the diagonal = 0x7FFF → (0,1), pivot_val=5.
- **All negative off-diagonal:** off-diagonal = -1 except [2][0]=-2 → (0,1), pivot_val=-1.
- **Hold and stream:**
  - Apply a new matrix with in_valid=0 → the outputs are unchanged and out_valid=0.
  - Then apply back-to-back valid matrices on consecutive cycles → each result appears exactly one cycle after its input.
